// File: rtl/psum_resolver.sv
// Resolves a carry-save partial-sum pair into one two's-complement word with a
// chunked multi-cycle carry-propagate adder, then rounds, shifts and saturates to 16 bits.
`timescale 1ns/1ps
module psum_resolver #(
    parameter int ARRAYSIZE = 16,
    parameter int CHUNK     = 8,
    parameter int SHIFT     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ARRAYSIZE+15:0] psum0,
    input  logic [ARRAYSIZE+15:0] psum1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ARRAYSIZE+15:0] sum_full,
    output logic [15:0]          result,
    output logic                 sat
);
    localparam int BUS    = ARRAYSIZE + 16;
    localparam int NCHUNK = (BUS + CHUNK - 1) / CHUNK;
    localparam int PADW   = NCHUNK * CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic        [BUS:0] ONE  = (BUS+1)'(1);
    localparam logic signed [BUS:0] RND  = $signed((ONE << SHIFT) >> 1);
    localparam logic signed [BUS:0] MAXV = (BUS+1)'(32767);
    localparam logic signed [BUS:0] MINV = (BUS+1)'(-32768);

    typedef enum logic [1:0] {IDLE, ADD, OUT} state_t;

    state_t                  state_q, state_d;
    logic                    accept;
    logic                    last;
    logic [KW-1:0]           k_q;
    logic                    carry_q;
    logic [PADW-1:0]         a_p0, b_p0;
    logic [PADW-CHUNK-1:0]   acc_p0;
    logic [CHUNK:0]          chunk_sum;
    logic [PADW-1:0]         full_p0;

    // Sign-extend one bit first so the half-LSB rounding add can never wrap.
    function automatic logic [16:0] round_sat(input logic signed [BUS-1:0] s);
        logic signed [BUS:0] r;
        r = {s[BUS-1], s};
        r = (r + RND) >>> SHIFT;
        if (r > MAXV)
            return {1'b1, 16'h7fff};
        else if (r < MINV)
            return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    assign last      = (k_q == KW'(NCHUNK - 1));
    assign chunk_sum = {1'b0, a_p0[CHUNK-1:0]} + {1'b0, b_p0[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};
    assign full_p0   = {chunk_sum[CHUNK-1:0], acc_p0};

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (last)
                    state_d = OUT;
            end
            OUT: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept  = 1'b1;
                        state_d = ADD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: operands shift down one chunk per cycle, resolved chunks enter acc_p0 from the top.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= PADW'(psum0);
            b_p0 <= PADW'(psum1);
        end else if (state_q == ADD) begin
            a_p0   <= a_p0 >> CHUNK;
            b_p0   <= b_p0 >> CHUNK;
            acc_p0 <= full_p0[PADW-1:CHUNK];
        end
    end

    // Stage p1: output registers are loaded on the edge that resolves the top chunk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            sum_full  <= '0;
            result    <= '0;
            sat       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                k_q     <= '0;
                carry_q <= 1'b0;
            end else if (state_q == ADD) begin
                k_q     <= last ? '0 : k_q + KW'(1);
                carry_q <= chunk_sum[CHUNK];
            end
            if (state_q == ADD && last) begin
                out_valid     <= 1'b1;
                sum_full      <= full_p0[BUS-1:0];
                {sat, result} <= round_sat($signed(full_p0[BUS-1:0]));
            end else if (state_q == OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_resolver.sv
// Directed scoreboard bench for psum_resolver: two instances (SHIFT=0 and SHIFT=4)
// share stimulus; expected results are queued at each input handshake.
`timescale 1ns/1ps
module tb_psum_resolver;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [31:0] psum0, psum1;
    logic        in_ready0, in_ready4, ov0, ov4, sat0, sat4;
    logic [31:0] sf0, sf4;
    logic [15:0] res0, res4;

    typedef struct packed {
        logic [31:0] sum;
        logic [15:0] r0;
        logic        s0;
        logic [15:0] r4;
        logic        s4;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] tab_a [12] = '{32'h0000_0005, 32'h0000_9C40, 32'hFFFF_63C0, 32'h00FF_FFFF,
                                32'h0000_0018, 32'hFFFF_FFE8, 32'h0000_7FFF, 32'h0000_8000,
                                32'hFFFF_8000, 32'hFFFF_7FFF, 32'h8000_0000, 32'h0007_FFF7};
    logic [31:0] tab_b [12] = '{32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0000, 32'h00FF_FFFF,
                                32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                                32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001};

    always #5 clk = ~clk;

    psum_resolver #(.ARRAYSIZE(16), .CHUNK(8), .SHIFT(0)) d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .psum0(psum0), .psum1(psum1), .out_valid(ov0), .out_ready(out_ready),
        .sum_full(sf0), .result(res0), .sat(sat0));

    psum_resolver #(.ARRAYSIZE(16), .CHUNK(8), .SHIFT(4)) d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .psum0(psum0), .psum1(psum1), .out_valid(ov4), .out_ready(out_ready),
        .sum_full(sf4), .result(res4), .sat(sat4));

    function automatic logic [16:0] ref_rs(input logic [31:0] s, input int sh);
        longint v = longint'($signed(s));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.sum = a + b;
        {e.s0, e.r0} = ref_rs(e.sum, 0);
        {e.s4, e.r4} = ref_rs(e.sum, 4);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_vals(input exp_t e);
        chk("sum_full0", sf0, e.sum);
        chk("sum_full4", sf4, e.sum);
        chk("result0", 32'(res0), 32'(e.r0));
        chk("sat0", 32'(sat0), 32'(e.s0));
        chk("result4", 32'(res4), 32'(e.r4));
        chk("sat4", 32'(sat4), 32'(e.s4));
    endtask

    task automatic check_out();
        exp_t e;
        vectors++;
        assert (q.size() > 0) else begin
            miscompares++;
            $error("FAIL sb_underflow: observed depth %0d expected >0", q.size());
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid0", 32'(ov0), 32'd1);
            chk("out_valid4", 32'(ov4), 32'd1);
            check_vals(e);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        psum0 = a; psum1 = b; in_valid = 1'b1;
        #1;
        while (!in_ready0 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk("in_ready_wait", 32'(in_ready0), 32'd1);
        q.push_back(model(a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        psum0 = $urandom; psum1 = $urandom;
    endtask

    task automatic recv(input int exp_lat);
        int n = 0;
        out_ready = 1'b1;
        do begin
            @(negedge clk); n++;
        end while (!ov0 && n < 40);
        chk("latency", 32'(n), 32'(exp_lat));
        check_out();
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t ea;
        logic [31:0] na, nb;
        int n;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; psum0 = '0; psum1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        check_vals('0);

        for (int i = 0; i < 12; i++) begin
            send(tab_a[i], tab_b[i]);
            recv(5);
        end

        for (int i = 0; i < 6; i++) begin
            send($urandom, $urandom);
            recv(5);
        end

        // Backpressure: result held with out_ready low while new inputs wiggle.
        out_ready = 1'b0;
        send(32'h0001_2340, 32'h0000_0010);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!ov0 && n < 40);
        chk("bp_latency", 32'(n), 32'd5);
        ea = q[0];
        for (int i = 0; i < 3; i++) begin
            psum0 = $urandom; psum1 = $urandom; in_valid = 1'b1;
            #1;
            chk("bp_hold_valid", 32'(ov0), 32'd1);
            chk("bp_in_ready", 32'(in_ready0), 32'd0);
            check_vals(ea);
            @(negedge clk);
        end
        na = 32'hFFFF_F000; nb = 32'h0000_0123;
        psum0 = na; psum1 = nb; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(in_ready0), 32'd1);
        check_out();
        q.push_back(model(na, nb));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_valid_drop", 32'(ov0), 32'd0);
        recv(5);

        // Reset during the second ADD cycle abandons the operation.
        send(32'h00AB_0000, 32'h0000_0011);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid0", 32'(ov0), 32'd0);
        chk("mrst_out_valid4", 32'(ov4), 32'd0);
        check_vals('0);
        void'(q.pop_back());
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mrst_in_ready", 32'(in_ready0), 32'd1);
            chk("mrst_no_stale", 32'(ov0 | ov4), 32'd0);
        end

        send(32'h0000_0100, 32'h0000_0080);
        recv(5);

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/psum_resolver.md
Name: psum_resolver

Overview:
- Drain-side consumer of the systolic carry-save accumulator. It takes the redundant partial-sum pair (psum0, psum1) at the bottom of a column and resolves it into a single two's-complement sum.
- Resolution uses a multi-cycle chunked carry-propagate adder, followed by optional round-and-shift and saturation to a 16-bit output.
- Sits between the accumulator column and the output buffer, with valid/ready on both sides.

Parameters:
- ARRAYSIZE, 16, array dimension. Bus width BUS = ARRAYSIZE+16.
- CHUNK, 8, bits resolved per add cycle. NCHUNK = ceil(BUS/CHUNK); the top chunk is zero-padded.
- SHIFT, 0, arithmetic right shift applied before saturation, range 0..BUS-2. Rounding is round-half-up when SHIFT>0.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  psum pair valid.
- in_ready  output  1  resolver can accept a pair.
- psum0  input  BUS  carry-save sum word.
- psum1  input  BUS  carry-save carry word.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum_full  output  BUS  resolved psum0+psum1, mod 2^BUS.
- result  output  16  rounded, shifted, saturated signed result.
- sat  output  1  result was clipped.

Behaviour:
- Arithmetic: sum_full = (psum0 + psum1) mod 2^BUS, interpreted as signed BUS-bit.
  - No bias correction is applied: the accumulator's sign-extension constants already cancel.
- Result path:
  - r = (sum_full + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed in BUS+1 bits so the rounding add never wraps.
  - r > 32767 gives result=32767, sat=1.
  - r < -32768 gives result=-32768, sat=1.
  - Otherwise result=r[15:0], sat=0.
- FSM states: IDLE, ADD, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch psum0/psum1, clear carry, set chunk index k=0, go to ADD.
- ADD:
  - Each cycle: {c, sum_full[k*CHUNK +: CHUNK]} = chunk0 + chunk1 + c; k increments.
  - After chunk NCHUNK-1, go to OUT. The round/shift/saturate is registered on that same edge.
- OUT:
  - out_valid=1. sum_full, result and sat are stable until the handshake.
  - out_ready=1: leave OUT. in_ready=1 in this state only when out_ready=1.
    - If in_valid is also high, the new pair is latched and the FSM goes straight to ADD (back-to-back).
    - Otherwise go to IDLE.
  - out_ready=0: hold all outputs and stay in OUT.
- Latency: in-handshake to out_valid = NCHUNK+1 cycles (5 for defaults). Sustained throughput is one result per NCHUNK+1 cycles.
- Inputs are sampled only at the in-handshake; changes to psum0/psum1 afterwards have no effect.
- Carry out of the top chunk is discarded (mod 2^BUS).
- Reset:
  - Values: state=IDLE, out_valid=0, sum_full=0, result=0, sat=0, k=0, carry=0.
  - in_ready goes to 1 on the first cycle after reset deasserts.
  - Reset asserted in ADD or OUT abandons the operation with no output.
  - Reset overrides a simultaneous in_valid.
- in_ready is combinational from state and out_ready. out_valid and the data outputs are registered.

Test Plan:
- Basic add:
  - Stimulus: SHIFT=0, psum0=32'h0000_0005, psum1=32'hFFFF_FFFD.
  - Required: after 5 cycles, out_valid=1, sum_full=32'h0000_0002, result=2, sat=0.
- Positive saturation:
  - Stimulus: psum0=32'h0000_9C40 (40000), psum1=0.
  - Required: result=16'h7FFF, sat=1, sum_full=32'h0000_9C40.
- Negative saturation with cross-chunk carries:
  - Stimulus: psum0=32'hFFFF_63C0 (-40000), psum1=0, then psum0=psum1=32'h00FF_FFFF.
  - Required: first result=16'h8000, sat=1. Second sum_full=32'h01FF_FFFE (carry ripples through every chunk).
- Rounding:
  - Stimulus: SHIFT=4, sum 24, then sum -24.
  - Required: result=2 for 24 (1.5 rounds up), result=-1 for -24 (-1.5 rounds up), sat=0 for both.
- Backpressure and back-to-back:
  - Stimulus: out_ready=0 for 3 cycles in OUT, with the inputs changed meanwhile.
  - Required: outputs held, in_ready=0.
  - Stimulus: raise out_ready with in_valid=1.
  - Required: next pair accepted the same cycle; next out_valid 5 cycles later.
- Reset mid-operation:
  - Stimulus: assert rst during the 2nd ADD cycle.
  - Required: next cycle out_valid=0, outputs zero, in_ready=1 after deassert, and no stale result is ever presented.
